// File: rtl/systick_service_master.sv
// Avalon-MM master that programs the systick timer and services its timeouts into ticks.
// Optional counter snapshot per tick is enabled with the SYSTICK_SNAPSHOT_EN macro.
module systick_service_master #(
    parameter logic [31:0] PERIOD_INIT = 32'd99999,
    parameter int unsigned CONTINUOUS  = 1,
    parameter int unsigned TICK_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  cfg_load,
    input  logic [31:0]           cfg_period,
    input  logic                  irq,
    output logic [2:0]            m_address,
    output logic                  m_chipselect,
    output logic                  m_write_n,
    output logic [15:0]           m_writedata,
    input  logic [15:0]           m_readdata,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [7:0]            spurious_count,
    output logic                  running,
    output logic [31:0]           snap_value
);

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 32;
    localparam int unsigned SW = 8;

    localparam logic [AW-1:0] ADDR_STATUS = 3'd0;
    localparam logic [AW-1:0] ADDR_CTRL   = 3'd1;
    localparam logic [AW-1:0] ADDR_PER_L  = 3'd2;
    localparam logic [AW-1:0] ADDR_PER_H  = 3'd3;
    localparam logic [AW-1:0] ADDR_SNAP_L = 3'd4;
    localparam logic [AW-1:0] ADDR_SNAP_H = 3'd5;

    // control word: ITO=1, CONT from parameter, START=1, STOP=0
    localparam logic [DW-1:0] CTRL_GO   = {12'b0, 1'b0, 1'b1, CONTINUOUS[0], 1'b1};
    localparam logic [DW-1:0] CTRL_STOP = 16'h0008;
    localparam logic [SW-1:0] SPUR_MAX  = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_RD_STAT,
        ST_RD_CAP,
        ST_CLR_STAT,
        ST_TICK,
        ST_WR_STOP,
        ST_SNAP_WR,
        ST_SNAP_RDL,
        ST_SNAP_RDH,
        ST_SNAP_CAPH
    } state_e;

    state_e                state_q, state_d;
    logic                  cs_q, cs_d;
    logic                  wr_n_q, wr_n_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic                  tick_q, tick_d;
    logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]         spur_q, spur_d;
    logic                  running_q, running_d;
    logic [PW-1:0]         period_q, period_d;
    logic                  cfg_pend_q, cfg_pend_d;
    logic                  stop_pend_q, stop_pend_d;
`ifdef SYSTICK_SNAPSHOT_EN
    logic [DW-1:0]         snap_lo_q, snap_lo_d;
    logic [PW-1:0]         snap_q, snap_d;
`endif

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cs_q        <= 1'b0;
            wr_n_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            tick_q      <= 1'b0;
            tick_cnt_q  <= '0;
            spur_q      <= '0;
            running_q   <= 1'b0;
            period_q    <= PERIOD_INIT;
            cfg_pend_q  <= 1'b0;
            stop_pend_q <= 1'b0;
`ifdef SYSTICK_SNAPSHOT_EN
            snap_lo_q   <= '0;
            snap_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            wr_n_q      <= wr_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tick_q      <= tick_d;
            tick_cnt_q  <= tick_cnt_d;
            spur_q      <= spur_d;
            running_q   <= running_d;
            period_q    <= period_d;
            cfg_pend_q  <= cfg_pend_d;
            stop_pend_q <= stop_pend_d;
`ifdef SYSTICK_SNAPSHOT_EN
            snap_lo_q   <= snap_lo_d;
            snap_q      <= snap_d;
`endif
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_WR_PL;
            ST_WR_PL:    state_d = ST_WR_PH;
            ST_WR_PH:    state_d = ST_WR_CTRL;
            ST_WR_CTRL:  state_d = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                if (stop || stop_pend_q) state_d = ST_WR_STOP;
                else if (cfg_pend_q)     state_d = ST_WR_PL;
                else if (irq)            state_d = ST_RD_STAT;
            end
            ST_RD_STAT:  state_d = ST_RD_CAP;
            ST_RD_CAP:   state_d = m_readdata[0] ? ST_CLR_STAT : ST_WAIT_IRQ;
`ifdef SYSTICK_SNAPSHOT_EN
            ST_CLR_STAT:  state_d = ST_SNAP_WR;
            ST_SNAP_WR:   state_d = ST_SNAP_RDL;
            ST_SNAP_RDL:  state_d = ST_SNAP_RDH;
            ST_SNAP_RDH:  state_d = ST_SNAP_CAPH;
            ST_SNAP_CAPH: state_d = ST_TICK;
`else
            ST_CLR_STAT:  state_d = ST_TICK;
`endif
            ST_TICK:     state_d = ST_WAIT_IRQ;
            ST_WR_STOP:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // output logic: bus fields are decoded from the state being entered so they align with it
    always_comb begin
        cs_d        = 1'b0;
        wr_n_d      = 1'b1;
        addr_d      = '0;
        wdata_d     = '0;
        tick_d      = 1'b0;
        tick_cnt_d  = tick_cnt_q;
        spur_d      = spur_q;
        running_d   = running_q;
        period_d    = cfg_load ? cfg_period : period_q;
        cfg_pend_d  = cfg_load | (cfg_pend_q & (state_d != ST_WR_PL));
        stop_pend_d = stop_pend_q;
`ifdef SYSTICK_SNAPSHOT_EN
        snap_lo_d   = snap_lo_q;
        snap_d      = snap_q;
`endif

        if (stop && (state_q != ST_IDLE || start)) stop_pend_d = 1'b1;
        if (state_d == ST_WR_STOP)                 stop_pend_d = 1'b0;

        if (state_q == ST_RD_CAP && !m_readdata[0] && spur_q != SPUR_MAX)
            spur_d = spur_q + 8'd1;

        case (state_d)
            ST_WR_PL: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_PER_L; wdata_d = period_q[15:0];
            end
            ST_WR_PH: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_PER_H; wdata_d = period_q[31:16];
            end
            ST_WR_CTRL: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_CTRL; wdata_d = CTRL_GO;
                running_d = 1'b1;
            end
            ST_RD_STAT: begin
                cs_d = 1'b1; addr_d = ADDR_STATUS;
            end
            ST_CLR_STAT: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_STATUS;
            end
            ST_TICK: begin
                tick_d     = 1'b1;
                tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
            end
            ST_WR_STOP: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_CTRL; wdata_d = CTRL_STOP;
                running_d = 1'b0;
            end
            ST_SNAP_WR: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_SNAP_L;
            end
            ST_SNAP_RDL: begin
                cs_d = 1'b1; addr_d = ADDR_SNAP_L;
            end
            ST_SNAP_RDH: begin
                cs_d = 1'b1; addr_d = ADDR_SNAP_H;
            end
            default: ;
        endcase

`ifdef SYSTICK_SNAPSHOT_EN
        // low word arrives while the high read is on the bus; both publish together on TICK
        if (state_q == ST_SNAP_RDH)  snap_lo_d = m_readdata;
        if (state_q == ST_SNAP_CAPH) snap_d    = {m_readdata, snap_lo_q};
`endif
    end

    assign m_address      = addr_q;
    assign m_chipselect   = cs_q;
    assign m_write_n      = wr_n_q;
    assign m_writedata    = wdata_q;
    assign tick           = tick_q;
    assign tick_count     = tick_cnt_q;
    assign spurious_count = spur_q;
    assign running        = running_q;

`ifdef SYSTICK_SNAPSHOT_EN
    assign snap_value = snap_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^m_readdata[DW-1:1];
    assign snap_value   = '0;
`endif

endmodule

// File: doc/systick_service_master.md
Name: systick_service_master

Overview:
- Avalon-MM style master that drives the systick timer slave (16-bit data, 3-bit word address, registered readdata, no waitrequest).
- Programs period and control at start-up or on request, then services each timer interrupt:
  - reads status,
  - clears the timeout flag,
  - emits a one-cycle tick and counts it.
- Sits between the timer slave and logic that needs a hardware tick without CPU involvement.

Parameters:
- PERIOD_INIT, 32'd99999, period loaded on start when no runtime period has been given.
- CONTINUOUS, 1, value written to the control CONT bit (1 = free-running).
- TICK_CNT_W, 32, width of tick_count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  pulse: program timer and begin servicing.
- stop  in  1  pulse: write STOP to the timer, return to IDLE.
- cfg_load  in  1  pulse: latch cfg_period and reprogram at the next safe point.
- cfg_period  in  32  new period value, sampled when cfg_load=1.
- irq  in  1  timer interrupt.
- m_address  out  3  word address to the timer.
- m_chipselect  out  1  bus select.
- m_write_n  out  1  active-low write strobe.
- m_writedata  out  16  write data.
- m_readdata  in  16  timer readdata, valid in the cycle after the read address is presented.
- tick  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  TICK_CNT_W  wrapping count of ticks.
- spurious_count  out  8  saturating count of irq services that found TO=0.
- running  out  1  1 from control write until stop or reset.
- snap_value  out  32  counter snapshot (optional feature).

Behaviour:
- Reset is synchronous on reset_n=0 at posedge clk:
  - FSM goes to IDLE.
  - m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
  - tick=0, tick_count=0, spurious_count=0, running=0, snap_value=0.
  - Latched period returns to PERIOD_INIT; pending cfg_load and stop are cleared.
- Reset mid-transaction abandons it immediately; no further bus cycle is issued.
- All bus outputs are registered. Each bus access lasts exactly one cycle with m_chipselect=1. When idle, m_chipselect=0 and m_write_n=1.
- Timer address map: 0 status (bit0 TO, bit1 RUN; a write clears TO), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- FSM states:
  - IDLE: on start go to WR_PL.
  - WR_PL: write addr 2 = period[15:0].
  - WR_PH: write addr 3 = period[31:16].
  - WR_CTRL: write addr 1 = {12'b0, 1'b0, 1'b1, CONTINUOUS[0], 1'b1}, i.e. 0x0007 when CONTINUOUS=1; set running=1.
  - WAIT_IRQ: priority stop > cfg_load > irq.
    - stop goes to WR_STOP.
    - Pending cfg_load goes to WR_PL.
    - irq=1 goes to RD_STAT.
  - RD_STAT: read addr 0.
  - RD_CAP: sample m_readdata.
    - bit0=1: go to CLR_STAT.
    - bit0=0: spurious_count++ (saturating at 255), back to WAIT_IRQ.
  - CLR_STAT: write addr 0 with data 0.
  - TICK: tick=1 for one cycle, tick_count+1 (wraps at 2^TICK_CNT_W), go to WAIT_IRQ.
  - WR_STOP: write addr 1 = 0x0008, running=0, go to IDLE.
- Period writes always precede the control write, because a period write stops the timer.
- Ordering and latency:
  - Period write then control write (WR_PL to WR_CTRL) takes 3 consecutive cycles after start.
  - From irq seen in WAIT_IRQ to tick takes 4 cycles: RD_STAT, RD_CAP, CLR_STAT, TICK.
  - While servicing, irq stays high until the CLR_STAT write lands. WAIT_IRQ is re-entered only after TICK, so one timeout yields exactly one tick.
- stop or start pulses arriving outside their accepting state:
  - start is ignored unless in IDLE.
  - stop is latched and taken at the next WAIT_IRQ.
  - stop in IDLE is ignored.
- cfg_load in any state: cfg_period is latched immediately; the pending flag is serviced at the next WAIT_IRQ. If cfg_load arrives in IDLE, the new period is used by the next start.
- start and stop in the same cycle while in IDLE: start wins; the stop is latched and executes at the first WAIT_IRQ.

Optional Feature:
- SYSTICK_SNAPSHOT_EN
- Defined:
  - After CLR_STAT, insert SNAP_WR: write addr 4, data 0.
  - Then SNAP_RDL: read addr 4; SNAP_RDH: read addr 5, capturing the low word.
  - Then SNAP_CAPH: capture the high word.
  - snap_value updates atomically with {high, low} in the TICK cycle.
  - irq-to-tick latency becomes 8 cycles.
- Not defined: snap_value is constant 0 and irq-to-tick latency is 4 cycles.

Test Plan:
- Reset, then start with PERIOD_INIT=99999 -> bus writes addr2=0x869F, addr3=0x0001, addr1=0x0007 on 3 consecutive cycles; running=1; chipselect low otherwise.
- In WAIT_IRQ, raise irq with m_readdata model returning 0x0003 -> read addr0, write addr0 data 0, tick high one cycle 4 cycles after irq, tick_count=1.
- irq with readdata 0x0002 (TO=0) -> no write, no tick, spurious_count=1; 300 such events -> spurious_count stays at 255.
- cfg_load with cfg_period=0x0002_0010 during servicing -> after TICK, writes addr2=0x0010, addr3=0x0002, addr1=0x0007.
- stop in WAIT_IRQ -> write addr1=0x0008, running=0, FSM in IDLE; a further irq produces no bus activity; reset asserted during RD_CAP -> all outputs at reset values the next cycle.
- With SYSTICK_SNAPSHOT_EN, snapshot words 0x1234/0x0001 -> snap_value=0x00011234 when tick=1, tick 8 cycles after irq.
